btn_debounce: RTL and testbench
===============================

BTN_DEBOUNCE -- requirements
Module: btn_debounce

Interface
REQ-001 SHALL have parameter CLK_HZ, default 100000000, input clock frequency in Hz.
REQ-002 SHALL have parameter SAMPLE_HZ, default 1000, debounce sampling rate in Hz; DIV = CLK_HZ/SAMPLE_HZ, and DIV SHALL be >= 2.
REQ-003 SHALL have parameter STABLE_SAMPLES, default 16, consecutive equal samples needed to accept a level change; it SHALL be >= 2.
REQ-004 SHALL have port Clk  input  1  single clock for all logic.
REQ-005 SHALL have port Reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port Btn_In  input  1  raw, asynchronous, bouncing push-button level.
REQ-007 SHALL have port Btn_Level  output  1  debounced button level.
REQ-008 SHALL have port Btn_Pulse  output  1  one-Clk-cycle strobe per accepted press; this is the count enable for the downstream counter.
REQ-009 SHALL have port Sample_Tick  output  1  one-cycle sampling strobe, exported for debug.

Function
REQ-010 SHALL pass Btn_In through a 2-flop synchronizer; only the synchronized value (sync) is used by downstream logic.
REQ-011 SHALL generate Sample_Tick from a divider counting 0..DIV-1, asserted for one cycle when count == DIV-1, then wrapping to 0.
REQ-012 SHALL implement FSM states IDLE, PRESS_WAIT, PRESSED and RELEASE_WAIT, with stable counter cnt of width $clog2(STABLE_SAMPLES+1).
REQ-013 IDLE: when sync=1, go to PRESS_WAIT and set cnt=0; otherwise stay in IDLE.
REQ-014 PRESS_WAIT: in any cycle with sync=0, return to IDLE regardless of tick; on Sample_Tick with sync=1, increment cnt; on the tick where cnt reaches STABLE_SAMPLES, go to PRESSED.
REQ-015 PRESSED: when sync=0, go to RELEASE_WAIT and set cnt=0.
REQ-016 RELEASE_WAIT: in any cycle with sync=1, return to PRESSED; on Sample_Tick with sync=0, increment cnt; at STABLE_SAMPLES, go to IDLE.
REQ-017 Btn_Level SHALL be a registered output, 1 while the state is PRESSED or RELEASE_WAIT and 0 otherwise.
REQ-018 Btn_Pulse SHALL be registered and SHALL be 1 for exactly the single cycle after the edge that enters PRESSED from PRESS_WAIT.
REQ-019 A re-entry to PRESSED from RELEASE_WAIT SHALL NOT generate a pulse.
REQ-020 At most one Btn_Pulse SHALL occur per IDLE->PRESSED transition, independent of hold time.
REQ-021 Press acceptance latency SHALL be between 2+(STABLE_SAMPLES-1)*DIV+1 and 2+STABLE_SAMPLES*DIV+1 Clk cycles after Btn_In settles high.
REQ-022 The divider SHALL run freely, not reset by FSM activity; cnt SHALL saturate at STABLE_SAMPLES and never wrap.
REQ-023 An illegal state encoding SHALL return to IDLE on the next cycle.

Reset
REQ-024 Reset=1 SHALL immediately force the state to IDLE, cnt=0, divider=0, both synchronizer flops to 0, and Btn_Level=0, Btn_Pulse=0, Sample_Tick=0.
REQ-025 Reset asserted mid-operation, in any state, SHALL abort it without emitting a pulse.
REQ-026 After Reset deasserts, the first Sample_Tick SHALL occur DIV cycles later.

Structure
REQ-027 A shared package SHALL hold the FSM state typedef/encoding and the default CLK_HZ, SAMPLE_HZ and STABLE_SAMPLES constants.
REQ-028 The divider SHALL be a sub-module tick_gen (parameter DIV; ports Clk, Reset, Tick), instantiated once.
REQ-029 The RTL SHALL contain no derived or gated clocks; Btn_Pulse is a clock enable, not a clock.

Verification (bench parameters CLK_HZ=1000, SAMPLE_HZ=100 so DIV=10, STABLE_SAMPLES=4)
REQ-030 Clean press: Btn_In=1 held 200 cycles -> exactly one Btn_Pulse within 33..43 cycles of the rise; Btn_Level=1 from the same cycle.
REQ-031 Bouncing press: Btn_In toggles every 3 cycles for 30 cycles, then holds 1 for 100 cycles -> exactly one Btn_Pulse, occurring after the bouncing stops.
REQ-032 Glitch: a 1-cycle high then a 5-cycle high, with Btn_In=0 otherwise -> no Btn_Pulse and Btn_Level stays 0.
REQ-033 Bouncing release: hold 1, then toggle every 2 cycles for 20 cycles, then 0 -> Btn_Level falls once, within 33..43 cycles of the last edge, and no extra Btn_Pulse.
REQ-034 Reset mid-operation: assert Reset at cycle 25 of a held press -> all outputs 0 in the same cycle; after release of Reset with Btn_In still 1 -> one Btn_Pulse 33..43 cycles later.
REQ-035 Long hold: Btn_In=1 for 5000 cycles -> exactly one Btn_Pulse; Sample_Tick period is exactly 10 cycles throughout.

Source files
------------

// File: rtl/btn_debounce_pkg.sv
// Shared constants and FSM state encoding for the push-button debouncer.
// Default clock/sample rates and the stability requirement live here.
package btn_debounce_pkg;

  localparam int CLK_HZ_DEF         = 100000000;
  localparam int SAMPLE_HZ_DEF      = 1000;
  localparam int STABLE_SAMPLES_DEF = 16;

  typedef enum logic [1:0] {
    IDLE         = 2'b00,
    PRESS_WAIT   = 2'b01,
    PRESSED      = 2'b10,
    RELEASE_WAIT = 2'b11
  } deb_state_t;

endpackage

// File: rtl/btn_debounce_tick_gen.sv
// Free-running sample-rate divider: one-cycle registered strobe every DIV clocks.
// The first strobe after reset appears DIV cycles after reset release.
module tick_gen #(
  parameter int DIV = 100000
) (
  input  logic Clk,
  input  logic Reset,
  output logic Tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] count;

  // Divider counter and registered strobe on the wrap cycle.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      count <= {CW{1'b0}};
      Tick  <= 1'b0;
    end else begin
      if (count == LAST) begin
        count <= {CW{1'b0}};
        Tick  <= 1'b1;
      end else begin
        count <= count + CW'(1);
        Tick  <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/btn_debounce.sv
// Push-button debouncer: synchronizer, sampled stability FSM, registered
// debounced level and a single-cycle press strobe used as a count enable.
module btn_debounce
  import btn_debounce_pkg::*;
#(
  parameter int CLK_HZ         = CLK_HZ_DEF,
  parameter int SAMPLE_HZ      = SAMPLE_HZ_DEF,
  parameter int STABLE_SAMPLES = STABLE_SAMPLES_DEF
) (
  input  logic Clk,
  input  logic Reset,
  input  logic Btn_In,
  output logic Btn_Level,
  output logic Btn_Pulse,
  output logic Sample_Tick
);

  localparam int DIV = CLK_HZ / SAMPLE_HZ;
  localparam int CW  = $clog2(STABLE_SAMPLES + 1);
  localparam logic [CW-1:0] STABLE_C = CW'(STABLE_SAMPLES);

  logic          sync_meta;
  logic          sync;
  logic          tick;
  deb_state_t    state;
  deb_state_t    state_next;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;

  tick_gen #(.DIV(DIV)) u_tick_gen (
    .Clk   (Clk),
    .Reset (Reset),
    .Tick  (tick)
  );

  assign Sample_Tick = tick;

  // Two-flop synchronizer for the raw button level.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      sync_meta <= 1'b0;
      sync      <= 1'b0;
    end else begin
      sync_meta <= Btn_In;
      sync      <= sync_meta;
    end
  end

  // Next-state and stable-sample counting; a bounce back restarts the wait.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      IDLE: begin
        if (sync) begin
          state_next = PRESS_WAIT;
          cnt_next   = {CW{1'b0}};
        end else begin
          state_next = IDLE;
        end
      end
      PRESS_WAIT: begin
        if (!sync) begin
          state_next = IDLE;
          cnt_next   = {CW{1'b0}};
        end else if (tick) begin
          if (cnt >= STABLE_C - CW'(1)) begin
            cnt_next   = STABLE_C;
            state_next = PRESSED;
          end else begin
            cnt_next = cnt + CW'(1);
          end
        end else begin
          state_next = PRESS_WAIT;
        end
      end
      PRESSED: begin
        if (!sync) begin
          state_next = RELEASE_WAIT;
          cnt_next   = {CW{1'b0}};
        end else begin
          state_next = PRESSED;
        end
      end
      RELEASE_WAIT: begin
        if (sync) begin
          state_next = PRESSED;
          cnt_next   = {CW{1'b0}};
        end else if (tick) begin
          if (cnt >= STABLE_C - CW'(1)) begin
            cnt_next   = STABLE_C;
            state_next = IDLE;
          end else begin
            cnt_next = cnt + CW'(1);
          end
        end else begin
          state_next = RELEASE_WAIT;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = {CW{1'b0}};
      end
    endcase
  end

  // State register; outputs are derived from the next state so they line up with it.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state     <= IDLE;
      cnt       <= {CW{1'b0}};
      Btn_Level <= 1'b0;
      Btn_Pulse <= 1'b0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      Btn_Level <= (state_next == PRESSED) || (state_next == RELEASE_WAIT);
      Btn_Pulse <= (state == PRESS_WAIT) && (state_next == PRESSED);
    end
  end

endmodule

// File: tb/tb_btn_debounce.sv
// Directed bench for btn_debounce with DIV=10, STABLE_SAMPLES=4.
// Expected windows and cycle counts are worked out by hand from the requirements.
module tb_btn_debounce;

  logic Clk;
  logic Reset;
  logic Btn_In;
  logic Btn_Level;
  logic Btn_Pulse;
  logic Sample_Tick;

  int checks = 0;
  int errors = 0;

  int cyc, gcyc;
  int pulses, first_pulse;
  int rises, first_rise;
  int falls, first_fall;
  int first_tick, last_tick;
  bit prev_level;
  bit track;

  btn_debounce #(
    .CLK_HZ         (1000),
    .SAMPLE_HZ      (100),
    .STABLE_SAMPLES (4)
  ) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .Btn_In      (Btn_In),
    .Btn_Level   (Btn_Level),
    .Btn_Pulse   (Btn_Pulse),
    .Sample_Tick (Sample_Tick)
  );

  always #5 Clk = ~Clk;

  task automatic check_eq(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_rng(input string tag, input int obs, input int lo, input int hi);
    checks++;
    assert ((obs >= lo && obs <= hi) === 1'b1) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
    end
  endtask

  task automatic clear_stats();
    cyc         = 0;
    pulses      = 0;
    first_pulse = -1;
    rises       = 0;
    first_rise  = -1;
    falls       = 0;
    first_fall  = -1;
    first_tick  = -1;
    prev_level  = Btn_Level;
  endtask

  // Advance n cycles, observing 1 time unit after each rising edge.
  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge Clk);
      #1;
      cyc++;
      gcyc++;
      if (Btn_Pulse) begin
        pulses++;
        if (first_pulse < 0) first_pulse = cyc;
      end
      if (Btn_Level && !prev_level) begin
        rises++;
        if (first_rise < 0) first_rise = cyc;
      end
      if (!Btn_Level && prev_level) begin
        falls++;
        if (first_fall < 0) first_fall = cyc;
      end
      prev_level = Btn_Level;
      if (Sample_Tick) begin
        if (first_tick < 0) first_tick = cyc;
        if (track && last_tick >= 0) check_eq("tick_period", gcyc - last_tick, 10);
        last_tick = gcyc;
      end
    end
  endtask

  initial begin
    Clk       = 1'b0;
    Reset     = 1'b1;
    Btn_In    = 1'b0;
    gcyc      = 0;
    last_tick = -1;
    track     = 1'b0;

    // Reset state
    #2;
    check_eq("reset_level", int'(Btn_Level), 0);
    check_eq("reset_pulse", int'(Btn_Pulse), 0);
    check_eq("reset_tick", int'(Sample_Tick), 0);
    clear_stats();
    run(2);
    Reset = 1'b0;

    // First tick DIV cycles after reset release
    clear_stats();
    run(20);
    check_eq("first_tick_after_reset", first_tick, 10);
    check_eq("idle_no_pulse", pulses, 0);

    // Clean press
    clear_stats();
    Btn_In = 1'b1;
    run(200);
    check_eq("clean_pulse_count", pulses, 1);
    check_rng("clean_pulse_latency", first_pulse, 33, 43);
    check_eq("clean_level_same_cycle", first_rise, first_pulse);
    check_eq("clean_level_held", int'(Btn_Level), 1);
    clear_stats();
    Btn_In = 1'b0;
    run(60);
    check_eq("clean_release_falls", falls, 1);
    check_rng("clean_release_latency", first_fall, 33, 43);
    check_eq("clean_release_no_pulse", pulses, 0);

    // Bouncing press
    clear_stats();
    for (int seg = 0; seg < 10; seg++) begin
      Btn_In = ((seg % 2) == 0);
      run(3);
    end
    Btn_In = 1'b1;
    run(100);
    check_eq("bounce_pulse_count", pulses, 1);
    check_rng("bounce_pulse_after_settle", first_pulse - 30, 33, 43);
    clear_stats();
    Btn_In = 1'b0;
    run(60);
    check_eq("bounce_release_level", int'(Btn_Level), 0);

    // Glitches
    clear_stats();
    Btn_In = 1'b1;
    run(1);
    Btn_In = 1'b0;
    run(5);
    Btn_In = 1'b1;
    run(5);
    Btn_In = 1'b0;
    run(60);
    check_eq("glitch_no_pulse", pulses, 0);
    check_eq("glitch_no_level", rises, 0);
    check_eq("glitch_level_low", int'(Btn_Level), 0);

    // Bouncing release
    clear_stats();
    Btn_In = 1'b1;
    run(60);
    check_eq("brel_press_pulse", pulses, 1);
    clear_stats();
    for (int seg = 0; seg < 10; seg++) begin
      Btn_In = ((seg % 2) == 1);
      run(2);
    end
    Btn_In = 1'b0;
    run(60);
    check_eq("brel_falls", falls, 1);
    check_rng("brel_fall_latency", first_fall - 20, 33, 43);
    check_eq("brel_no_pulse", pulses, 0);
    check_eq("brel_no_rise", rises, 0);

    // Reset in the middle of a press
    clear_stats();
    Btn_In = 1'b1;
    run(25);
    Reset = 1'b1;
    #1;
    check_eq("midrst_level", int'(Btn_Level), 0);
    check_eq("midrst_pulse", int'(Btn_Pulse), 0);
    check_eq("midrst_tick", int'(Sample_Tick), 0);
    clear_stats();
    run(3);
    check_eq("midrst_hold_no_pulse", pulses + rises, 0);
    Reset = 1'b0;
    clear_stats();
    run(60);
    check_eq("midrst_first_tick", first_tick, 10);
    check_eq("midrst_pulse_count", pulses, 1);
    check_rng("midrst_pulse_latency", first_pulse, 33, 43);
    clear_stats();
    Btn_In = 1'b0;
    run(60);
    check_eq("midrst_release_falls", falls, 1);

    // Long hold with tick-period tracking
    clear_stats();
    last_tick = -1;
    track     = 1'b1;
    Btn_In    = 1'b1;
    run(5000);
    track = 1'b0;
    check_eq("long_pulse_count", pulses, 1);
    check_eq("long_level_rises", rises, 1);
    check_eq("long_level_held", int'(Btn_Level), 1);
    clear_stats();
    Btn_In = 1'b0;
    run(60);
    check_eq("long_release_level", int'(Btn_Level), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
